oversample_chan_arbiter: RTL and testbench
==========================================

# oversample_chan_arbiter

Round-robin scheduler that merges N_CHAN independent ADC sample streams into the single time-multiplexed `dv/chan/data` stream consumed by the oversample filter. Each channel has a one-entry holding register. One pending sample is granted per cycle. Per-channel enables and sticky overrun flags are configured and cleared over the common endpoint write bus (`wr_en/wr_addr/wr_chan/wr_data`), with addresses from `ep_map.vh`.

## Interface
Parameters:
- `W_CHAN`, 5, channel index width
- `N_CHAN`, 8, number of input channels (≤ 2**W_CHAN)
- `W_DATA`, 18, signed sample width
- `W_WR_ADDR`, 16, write-bus address width
- `W_WR_CHAN`, 16, write-bus channel width
- `W_WR_DATA`, 48, write-bus data width
- `EN_INIT`, {N_CHAN{1'b1}}, channel-enable value loaded on reset

Ports:
- `clk_in` input 1: the single clock
- `rst_in` input 1: reset, synchronous, active-high
- `adc_dv_in` input N_CHAN: per-channel sample strobe, one-cycle pulses
- `adc_data_in` input N_CHAN*W_DATA: channel i occupies bits [i*W_DATA +: W_DATA], signed
- `wr_en` input 1: write strobe
- `wr_addr` input W_WR_ADDR: write address (`arb_en_addr`, `arb_ovr_clr_addr`)
- `wr_chan` input W_WR_CHAN: target channel
- `wr_data` input W_WR_DATA: write data; only bit 0 is used
- `dv_out` input-to-filter strobe, output 1
- `chan_out` output W_CHAN: granted channel index
- `data_out` output W_DATA: granted sample, signed
- `overrun_out` output N_CHAN: sticky per-channel overrun flags

## Operation
- State per channel: `hold[i]` (W_DATA), `pending[i]`, `en[i]`, `ovr[i]`. Global state: round-robin pointer `ptr` (W_CHAN, range 0..N_CHAN-1).
- Capture: if `adc_dv_in[i]` and `en[i]`, then `hold[i] <= sample` and `pending[i] <= 1`. Strobes on disabled channels are ignored.
- Arbitration (combinational, from registered state): the candidate set is `pending & en`. The grant goes to the first candidate found searching ptr, ptr+1, …, wrapping modulo N_CHAN. If the set is empty, there is no grant.
- On a grant g:
  - register `dv_out=1`, `chan_out=g`, `data_out=hold[g]`
  - clear `pending[g]`
  - set `ptr <= (g+1) mod N_CHAN`
- With no grant: `dv_out <= 0`. `chan_out`, `data_out` and `ptr` hold their values.
- Same-channel capture and grant in one cycle: the grant outputs the old `hold[g]`, the new sample is stored, and `pending[g]` stays 1.
- Capture while `pending[i]=1` and channel i is not granted this cycle: the new sample overwrites (newest wins) and `ovr[i] <= 1`.
- `wr_en && wr_chan < N_CHAN && wr_addr == arb_en_addr`: `en[wr_chan] <= wr_data[0]`. When a channel is disabled, its `pending` clears in the same edge, and it is not granted in that cycle's arbitration.
- `wr_en && wr_chan < N_CHAN && wr_addr == arb_ovr_clr_addr`: clear `ovr[wr_chan]`. If an overrun event occurs on the same channel in the same cycle, the set wins.
- Writes with `wr_chan ≥ N_CHAN` or any other address have no effect.
- `overrun_out = ovr` (registered).

## Timing
- Reset, synchronous, evaluated on every edge with `rst_in=1`:
  - `dv_out=0`, `chan_out=0`, `data_out=0`, `overrun_out=0`
  - `pending=0`, `ptr=0`, `hold=0`, `en=EN_INIT`
  - write-bus and ADC inputs are ignored while `rst_in=1`
- Reset mid-operation discards all pending samples; no `dv_out` is emitted for them.
- Latency: a strobe in cycle t makes `pending` visible in t+1. If that channel is granted in t+1, `dv_out` is high in t+2 (minimum 2 cycles).
- Throughput: at most one grant per cycle. Worst-case wait for a pending channel is N_CHAN cycles.
- No overrun is possible if each channel strobes at most once every N_CHAN cycles.
- `dv_out` is a one-cycle pulse per grant. The filter has no backpressure, so grants are never stalled.

## Test plan
- Reset then a single strobe: `adc_dv_in[3]=1`, data 18'sh1FFFF in cycle t → in cycle t+2: `dv_out=1`, `chan_out=3`, `data_out=18'sh1FFFF`; `dv_out=0` in t+3.
- All 8 channels strobe in the same cycle with data i*10 → 8 consecutive `dv_out` cycles with `chan_out` 0,1,…,7 and the matching data; after that, `ptr=0`.
- Fairness: channels 0 and 5 strobe every cycle → grants alternate 0,5,0,5,…; both `overrun_out` bits set.
- Overrun/newest-wins: channel 2 disabled via `arb_en_addr` write (`wr_data=0`), re-enabled, then strobed with 7 then −7 while channel 1 is strobed first → channel 2 outputs −7 and `overrun_out[2]=1`. An `arb_ovr_clr_addr` write clears it; a clear coincident with a new overrun leaves the bit 1.
- Disable clears pending: channel 4 pending, then an `arb_en_addr` write of 0 → no grant for 4; subsequent strobes on channel 4 are ignored until re-enabled. A write with `wr_chan=9` changes nothing.
- Mid-stream reset: 4 channels pending, assert `rst_in` for one cycle → no `dv_out` afterwards; all outputs 0; `en` returns to `EN_INIT`.

Source files
------------

// File: rtl/oversample_chan_arbiter.sv
// oversample_chan_arbiter
//
// Round-robin scheduler that merges N_CHAN independent ADC sample streams
// into the single time-multiplexed dv/chan/data stream consumed by the
// oversample filter. Every channel owns a one-entry holding register, and at
// most one pending sample is granted per cycle. Per-channel enables and
// sticky overrun flags are written over the common endpoint write bus.
//
// Ports:
//   clk_in       - single clock
//   rst_in       - synchronous active-high reset
//   adc_dv_in    - per-channel sample strobes (one-cycle pulses)
//   adc_data_in  - packed samples, channel i at [i*W_DATA +: W_DATA], signed
//   wr_en        - endpoint write strobe
//   wr_addr      - endpoint address (ARB_EN_ADDR / ARB_OVR_CLR_ADDR)
//   wr_chan      - target channel of the write
//   wr_data      - write data, only bit 0 is meaningful
//   dv_out       - one-cycle strobe per granted sample
//   chan_out     - granted channel index
//   data_out     - granted sample, signed
//   overrun_out  - sticky per-channel overrun flags
//
// ARB_EN_ADDR and ARB_OVR_CLR_ADDR carry the endpoint addresses from the
// system endpoint map; override them at instantiation to match it.

module oversample_chan_arbiter #(
    parameter int                     W_CHAN           = 5,
    parameter int                     N_CHAN           = 8,
    parameter int                     W_DATA           = 18,
    parameter int                     W_WR_ADDR        = 16,
    parameter int                     W_WR_CHAN        = 16,
    parameter int                     W_WR_DATA        = 48,
    parameter logic [N_CHAN-1:0]      EN_INIT          = {N_CHAN{1'b1}},
    parameter logic [W_WR_ADDR-1:0]   ARB_EN_ADDR      = W_WR_ADDR'(16'h0040),
    parameter logic [W_WR_ADDR-1:0]   ARB_OVR_CLR_ADDR = W_WR_ADDR'(16'h0041)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [N_CHAN-1:0]          adc_dv_in,
    input  logic [N_CHAN*W_DATA-1:0]   adc_data_in,
    input  logic                       wr_en,
    input  logic [W_WR_ADDR-1:0]       wr_addr,
    input  logic [W_WR_CHAN-1:0]       wr_chan,
    input  logic [W_WR_DATA-1:0]       wr_data,
    output logic                       dv_out,
    output logic [W_CHAN-1:0]          chan_out,
    output logic signed [W_DATA-1:0]   data_out,
    output logic [N_CHAN-1:0]          overrun_out
);

    // Per-channel state and the round-robin pointer
    logic [W_DATA-1:0] r_hold [N_CHAN];
    logic [N_CHAN-1:0] r_pending;
    logic [N_CHAN-1:0] r_en;
    logic [N_CHAN-1:0] r_ovr;
    logic [W_CHAN-1:0] r_ptr;

    // Write-bus decode results
    logic              w_wrChanOk;
    logic              w_enWr;
    logic              w_clrWr;
    logic [N_CHAN-1:0] w_enWrMask;
    logic [N_CHAN-1:0] w_disMask;
    logic [N_CHAN-1:0] w_clrMask;

    // Capture / arbitration results
    logic [N_CHAN-1:0] w_capture;
    logic [N_CHAN-1:0] w_cand;
    logic              w_grantValid;
    logic [W_CHAN-1:0] w_grantIdx;
    logic [N_CHAN-1:0] w_grantOneHot;
    logic [W_DATA-1:0] w_grantData;
    logic [W_CHAN-1:0] w_ptrNext;

    // Only bit 0 of the write data carries information
    logic              w_unused;
    assign w_unused = ^{1'b0, wr_data[W_WR_DATA-1:1]};

    // Writes aimed at channels that do not exist are dropped entirely, so the
    // range check uses the full wr_chan width rather than a truncated index.
    assign w_wrChanOk = wr_en && (wr_chan < W_WR_CHAN'(N_CHAN));
    assign w_enWr     = w_wrChanOk && (wr_addr == ARB_EN_ADDR);
    assign w_clrWr    = w_wrChanOk && (wr_addr == ARB_OVR_CLR_ADDR);

    // Expand the decoded write into per-channel masks. A disabling write
    // takes effect in the same cycle: the channel drops out of arbitration
    // and any strobe arriving alongside the write is not captured.
    always_comb begin
        w_enWrMask = '0;
        w_disMask  = '0;
        w_clrMask  = '0;
        w_capture  = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            w_enWrMask[i] = w_enWr  && (wr_chan == W_WR_CHAN'(i));
            w_clrMask[i]  = w_clrWr && (wr_chan == W_WR_CHAN'(i));
            w_disMask[i]  = w_enWrMask[i] && !wr_data[0];
            w_capture[i]  = adc_dv_in[i] && r_en[i] && !w_disMask[i];
        end
    end

    assign w_cand = r_pending & r_en & ~w_disMask;

    // Round-robin search starting at r_ptr: first scan the channels at or
    // above the pointer in ascending order, then wrap around to the ones
    // below it. Splitting the scan this way keeps every array index a loop
    // constant, so no modulo arithmetic on the index is needed.
    always_comb begin
        w_grantValid  = 1'b0;
        w_grantIdx    = '0;
        w_grantOneHot = '0;
        w_grantData   = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (!w_grantValid && w_cand[i] && (W_CHAN'(i) >= r_ptr)) begin
                w_grantValid     = 1'b1;
                w_grantIdx       = W_CHAN'(i);
                w_grantOneHot[i] = 1'b1;
                w_grantData      = r_hold[i];
            end
        end
        for (int i = 0; i < N_CHAN; i++) begin
            if (!w_grantValid && w_cand[i] && (W_CHAN'(i) < r_ptr)) begin
                w_grantValid     = 1'b1;
                w_grantIdx       = W_CHAN'(i);
                w_grantOneHot[i] = 1'b1;
                w_grantData      = r_hold[i];
            end
        end
    end

    // The pointer moves to the channel just after the winner, wrapping at
    // N_CHAN, so the winner becomes the lowest priority next time round.
    assign w_ptrNext = (w_grantIdx == W_CHAN'(N_CHAN - 1)) ? '0
                                                            : w_grantIdx + W_CHAN'(1);

    // Output stage and pointer. Grants are never stalled because the filter
    // has no backpressure; without a grant only the strobe drops, chan/data
    // keep showing the last granted sample.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dv_out   <= 1'b0;
            chan_out <= '0;
            data_out <= '0;
            r_ptr    <= '0;
        end else begin
            dv_out <= w_grantValid;
            if (w_grantValid) begin
                chan_out <= w_grantIdx;
                data_out <= w_grantData;
                r_ptr    <= w_ptrNext;
            end
        end
    end

    // Per-channel holding registers, pending bits, enables and overrun flags.
    // Pending priority: a disable clears it, a capture sets it (so a capture
    // on the granted channel keeps it pending with the fresh sample), and
    // only then does a grant clear it. An overrun is a capture that lands on
    // a still-pending sample that is not leaving this cycle; it beats a
    // coincident clear so the event is never lost.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pending <= '0;
            r_en      <= EN_INIT;
            r_ovr     <= '0;
            for (int i = 0; i < N_CHAN; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (w_capture[i]) begin
                    r_hold[i] <= adc_data_in[i*W_DATA +: W_DATA];
                end

                if (w_disMask[i]) begin
                    r_pending[i] <= 1'b0;
                end else if (w_capture[i]) begin
                    r_pending[i] <= 1'b1;
                end else if (w_grantOneHot[i]) begin
                    r_pending[i] <= 1'b0;
                end

                if (w_enWrMask[i]) begin
                    r_en[i] <= wr_data[0];
                end

                if (w_capture[i] && r_pending[i] && !w_grantOneHot[i]) begin
                    r_ovr[i] <= 1'b1;
                end else if (w_clrMask[i]) begin
                    r_ovr[i] <= 1'b0;
                end
            end
        end
    end

    assign overrun_out = r_ovr;

endmodule

// File: tb/tb_oversample_chan_arbiter.sv
// tb_oversample_chan_arbiter
//
// Directed testbench for oversample_chan_arbiter with hand-computed
// expectations. Inputs are driven 1 time unit after each rising edge and
// outputs are sampled at the same point, i.e. they show what the previous
// edge registered.

module tb_oversample_chan_arbiter;

    localparam int W_CHAN    = 5;
    localparam int N_CHAN    = 8;
    localparam int W_DATA    = 18;
    localparam int W_WR_ADDR = 16;
    localparam int W_WR_CHAN = 16;
    localparam int W_WR_DATA = 48;
    localparam logic [W_WR_ADDR-1:0] EN_ADDR  = 16'h0040;
    localparam logic [W_WR_ADDR-1:0] CLR_ADDR = 16'h0041;

    logic                       clk_in = 1'b0;
    logic                       rst_in;
    logic [N_CHAN-1:0]          adc_dv_in;
    logic [N_CHAN*W_DATA-1:0]   adc_data_in;
    logic                       wr_en;
    logic [W_WR_ADDR-1:0]       wr_addr;
    logic [W_WR_CHAN-1:0]       wr_chan;
    logic [W_WR_DATA-1:0]       wr_data;
    logic                       dv_out;
    logic [W_CHAN-1:0]          chan_out;
    logic signed [W_DATA-1:0]   data_out;
    logic [N_CHAN-1:0]          overrun_out;

    int checks = 0;
    int errors = 0;

    oversample_chan_arbiter #(
        .W_CHAN           (W_CHAN),
        .N_CHAN           (N_CHAN),
        .W_DATA           (W_DATA),
        .W_WR_ADDR        (W_WR_ADDR),
        .W_WR_CHAN        (W_WR_CHAN),
        .W_WR_DATA        (W_WR_DATA),
        .EN_INIT          ({N_CHAN{1'b1}}),
        .ARB_EN_ADDR      (EN_ADDR),
        .ARB_OVR_CLR_ADDR (CLR_ADDR)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .adc_dv_in   (adc_dv_in),
        .adc_data_in (adc_data_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_chan     (wr_chan),
        .wr_data     (wr_data),
        .dv_out      (dv_out),
        .chan_out    (chan_out),
        .data_out    (data_out),
        .overrun_out (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock edge and settle just past it
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Raise the strobe of one channel with the given sample
    task automatic applyStimulus(input int ch, input logic [W_DATA-1:0] val);
        adc_dv_in[ch] = 1'b1;
        adc_data_in[ch*W_DATA +: W_DATA] = val;
    endtask

    task automatic clearStrobes();
        adc_dv_in = '0;
    endtask

    // One-cycle write on the endpoint bus
    task automatic writeBus(input logic [W_WR_ADDR-1:0] addr, input int ch, input logic bit0);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_chan = W_WR_CHAN'(ch);
        wr_data = {{(W_WR_DATA-1){1'b1}}, bit0};
        tick();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_chan = '0;
        wr_data = '0;
    endtask

    task automatic applyReset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    // Reset values, and strobes/writes during reset are ignored
    task automatic test_reset();
        rst_in = 1'b1;
        applyStimulus(3, 18'h00123);
        writeBus(EN_ADDR, 0, 1'b0);
        tick();
        tick();
        checks++;
        if ({dv_out, chan_out, data_out, overrun_out} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got dv=%b chan=%0d data=%h ovr=%b, expected all zero", dv_out, chan_out, data_out, overrun_out);
        end
        rst_in = 1'b0;
        clearStrobes();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (dv_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_ignores_strobe: cycle %0d got dv=%b expected 0", k, dv_out);
            end
        end
    endtask

    // Single strobe: two-cycle latency, one-cycle dv pulse
    task automatic test_single();
        applyStimulus(3, 18'h1FFFF);
        tick();
        clearStrobes();
        checks++;
        if (dv_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_t1: got dv=%b expected 0", dv_out);
        end
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd3, 18'h1FFFF}) begin
            errors++;
            $display("[TB] FAIL single_t2: got dv=%b chan=%0d data=%h expected dv=1 chan=3 data=1ffff", dv_out, chan_out, data_out);
        end
        tick();
        checks++;
        if (dv_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_t3: got dv=%b expected 0", dv_out);
        end
    endtask

    // All channels at once drain in order 0..7; pointer then wraps to 0
    task automatic test_all_chan();
        applyReset();
        for (int i = 0; i < N_CHAN; i++) applyStimulus(i, W_DATA'(i * 10));
        tick();
        clearStrobes();
        for (int k = 0; k < N_CHAN; k++) begin
            tick();
            checks++;
            if ({dv_out, chan_out, data_out} !== {1'b1, W_CHAN'(k), W_DATA'(k * 10)}) begin
                errors++;
                $display("[TB] FAIL all_chan_%0d: got dv=%b chan=%0d data=%0d expected dv=1 chan=%0d data=%0d", k, dv_out, chan_out, data_out, k, k * 10);
            end
        end
        tick();
        checks++;
        if (dv_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL all_chan_idle: got dv=%b expected 0", dv_out);
        end
        applyStimulus(7, 18'd777);
        applyStimulus(0, 18'd500);
        tick();
        clearStrobes();
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd0, 18'd500}) begin
            errors++;
            $display("[TB] FAIL ptr_wrap_first: got dv=%b chan=%0d data=%0d expected dv=1 chan=0 data=500", dv_out, chan_out, data_out);
        end
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd7, 18'd777}) begin
            errors++;
            $display("[TB] FAIL ptr_wrap_second: got dv=%b chan=%0d data=%0d expected dv=1 chan=7 data=777", dv_out, chan_out, data_out);
        end
        tick();
    endtask

    // Channels 0 and 5 strobing every cycle alternate and both overrun
    task automatic test_fairness();
        int n;
        logic [W_CHAN-1:0] expChan;
        logic [W_DATA-1:0] expData;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(0, W_DATA'(100 + c));
            applyStimulus(5, W_DATA'(200 + c));
            tick();
            if (c >= 1) begin
                n = c + 1;
                expChan = (n % 2 == 0) ? 5'd0 : 5'd5;
                expData = (n % 2 == 0) ? W_DATA'(100 + n - 2) : W_DATA'(200 + n - 2);
                checks++;
                if ({dv_out, chan_out, data_out} !== {1'b1, expChan, expData}) begin
                    errors++;
                    $display("[TB] FAIL fairness_%0d: got dv=%b chan=%0d data=%0d expected dv=1 chan=%0d data=%0d", n, dv_out, chan_out, data_out, expChan, expData);
                end
            end
        end
        clearStrobes();
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd5, 18'd207}) begin
            errors++;
            $display("[TB] FAIL fairness_drain5: got dv=%b chan=%0d data=%0d expected dv=1 chan=5 data=207", dv_out, chan_out, data_out);
        end
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd0, 18'd107}) begin
            errors++;
            $display("[TB] FAIL fairness_drain0: got dv=%b chan=%0d data=%0d expected dv=1 chan=0 data=107", dv_out, chan_out, data_out);
        end
        tick();
        checks++;
        if (overrun_out !== 8'b0010_0001) begin
            errors++;
            $display("[TB] FAIL fairness_overrun: got %b expected 00100001", overrun_out);
        end
        writeBus(CLR_ADDR, 0, 1'b0);
        writeBus(CLR_ADDR, 5, 1'b0);
        checks++;
        if (overrun_out !== 8'b0) begin
            errors++;
            $display("[TB] FAIL fairness_clear: got %b expected 00000000", overrun_out);
        end
    endtask

    // Disable/re-enable, newest-wins overwrite, clear, and set-beats-clear
    task automatic test_overrun();
        writeBus(EN_ADDR, 2, 1'b0);
        applyStimulus(2, 18'd5);
        tick();
        clearStrobes();
        tick();
        tick();
        checks++;
        if (dv_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disabled_ch2: got dv=%b expected 0", dv_out);
        end
        writeBus(EN_ADDR, 2, 1'b1);
        applyStimulus(1, 18'd11);
        applyStimulus(2, 18'd7);
        tick();
        clearStrobes();
        applyStimulus(2, 18'h3FFF9);
        tick();
        clearStrobes();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd1, 18'd11}) begin
            errors++;
            $display("[TB] FAIL ovr_grant1: got dv=%b chan=%0d data=%0d expected dv=1 chan=1 data=11", dv_out, chan_out, data_out);
        end
        checks++;
        if (overrun_out !== 8'b0000_0100) begin
            errors++;
            $display("[TB] FAIL ovr_flag2: got %b expected 00000100", overrun_out);
        end
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd2, 18'h3FFF9}) begin
            errors++;
            $display("[TB] FAIL ovr_newest: got dv=%b chan=%0d data=%0d expected dv=1 chan=2 data=-7", dv_out, chan_out, data_out);
        end
        writeBus(CLR_ADDR, 2, 1'b0);
        checks++;
        if (overrun_out !== 8'b0) begin
            errors++;
            $display("[TB] FAIL ovr_clear: got %b expected 00000000", overrun_out);
        end
        applyStimulus(1, 18'd21);
        applyStimulus(2, 18'd22);
        tick();
        clearStrobes();
        applyStimulus(2, 18'd23);
        writeBus(CLR_ADDR, 2, 1'b0);
        clearStrobes();
        checks++;
        if ({dv_out, chan_out, data_out, overrun_out} !== {1'b1, 5'd1, 18'd21, 8'b0000_0100}) begin
            errors++;
            $display("[TB] FAIL ovr_set_beats_clear: got dv=%b chan=%0d data=%0d ovr=%b expected dv=1 chan=1 data=21 ovr=00000100", dv_out, chan_out, data_out, overrun_out);
        end
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd2, 18'd23}) begin
            errors++;
            $display("[TB] FAIL ovr_after_clear_grant: got dv=%b chan=%0d data=%0d expected dv=1 chan=2 data=23", dv_out, chan_out, data_out);
        end
        writeBus(CLR_ADDR, 2, 1'b0);
    endtask

    // Disabling drops a pending sample; out-of-range writes do nothing
    task automatic test_disable();
        applyStimulus(4, 18'd44);
        tick();
        clearStrobes();
        writeBus(EN_ADDR, 4, 1'b0);
        checks++;
        if (dv_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disable_same_cycle: got dv=%b chan=%0d expected dv=0", dv_out, chan_out);
        end
        tick();
        checks++;
        if (dv_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disable_pending_dropped: got dv=%b chan=%0d expected dv=0", dv_out, chan_out);
        end
        applyStimulus(4, 18'd45);
        tick();
        clearStrobes();
        tick();
        checks++;
        if (dv_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disable_strobe_ignored: got dv=%b chan=%0d expected dv=0", dv_out, chan_out);
        end
        writeBus(EN_ADDR, 9, 1'b0);
        applyStimulus(1, 18'd31);
        tick();
        clearStrobes();
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd1, 18'd31}) begin
            errors++;
            $display("[TB] FAIL out_of_range_write: got dv=%b chan=%0d data=%0d expected dv=1 chan=1 data=31", dv_out, chan_out, data_out);
        end
        writeBus(EN_ADDR, 4, 1'b1);
        applyStimulus(4, 18'd46);
        tick();
        clearStrobes();
        tick();
        checks++;
        if ({dv_out, chan_out, data_out, overrun_out} !== {1'b1, 5'd4, 18'd46, 8'b0}) begin
            errors++;
            $display("[TB] FAIL reenable_ch4: got dv=%b chan=%0d data=%0d ovr=%b expected dv=1 chan=4 data=46 ovr=0", dv_out, chan_out, data_out, overrun_out);
        end
    endtask

    // Reset with samples pending discards them and restores the enables
    task automatic test_midreset();
        writeBus(EN_ADDR, 6, 1'b0);
        applyStimulus(0, 18'd1);
        applyStimulus(2, 18'd2);
        applyStimulus(4, 18'd3);
        applyStimulus(7, 18'd4);
        tick();
        clearStrobes();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        checks++;
        if ({dv_out, chan_out, data_out, overrun_out} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got dv=%b chan=%0d data=%0d ovr=%b expected all zero", dv_out, chan_out, data_out, overrun_out);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (dv_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_no_dv: cycle %0d got dv=%b chan=%0d expected dv=0", k, dv_out, chan_out);
            end
        end
        applyStimulus(6, 18'd66);
        tick();
        clearStrobes();
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd6, 18'd66}) begin
            errors++;
            $display("[TB] FAIL midreset_en_init: got dv=%b chan=%0d data=%0d expected dv=1 chan=6 data=66", dv_out, chan_out, data_out);
        end
    endtask

    initial begin
        rst_in      = 1'b1;
        adc_dv_in   = '0;
        adc_data_in = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_chan     = '0;
        wr_data     = '0;
        #1;
        test_reset();
        test_single();
        test_all_chan();
        test_fairness();
        test_overrun();
        test_disable();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
